// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, issue-controller states
// and Q15 constants used by the execute-side FPU logic.
package fpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_MUL    = 4'b0010;
  localparam logic [3:0] OP_DIV    = 4'b0011;
  localparam logic [3:0] OP_CPSGN  = 4'b0100;
  localparam logic [3:0] OP_CPSGNN = 4'b0101;
  localparam logic [3:0] OP_XORSGN = 4'b0110;
  localparam logic [3:0] OP_LE     = 4'b1000;
  localparam logic [3:0] OP_LT     = 4'b1001;
  localparam logic [3:0] OP_EQ     = 4'b1010;
  localparam logic [3:0] OP_MIN    = 4'b1100;
  localparam logic [3:0] OP_MAX    = 4'b1101;

  localparam logic [3:0] OP_IDLE   = 4'b0000;

  localparam logic [63:0] Q15_ONE  = 64'h8000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

endpackage

// File: rtl/fpu_op_legal.sv
// FPU opcode decoder: legality and divide detection.
// Shared by the issue controller and the instruction decoder.
module fpu_op_legal
  import fpu_pkg::*;
(
  input  logic [3:0] op,
  output logic       legal,
  output logic       is_div
);

  always_comb begin
    legal  = 1'b0;
    is_div = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_MUL,
      OP_CPSGN, OP_CPSGNN, OP_XORSGN,
      OP_LE, OP_LT, OP_EQ,
      OP_MIN, OP_MAX: legal = 1'b1;
      OP_DIV: begin
        legal  = 1'b1;
        is_div = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller between execute stage and the Q15 FPU:
// one op in flight, divide sequenced via launch/busy.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int TAG_W       = 4,
  parameter int DIV_TIMEOUT = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [3:0]        fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic              fpu_busy,
  input  logic [DATA_W-1:0] fpu_res
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state, state_nx;
  logic [3:0]         op_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   cnt;
  logic               op_legal, op_div;
  logic               accept;
  logic               cap_ok, cap_err;

  fpu_op_legal u_legal (
    .op     (op_q),
    .legal  (op_legal),
    .is_div (op_div)
  );

  // A stale (relaunched or aborted) divide blocks new issue
  assign in_ready  = (state == ST_IDLE) & ~fpu_busy;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == ST_RESP);

  always_comb begin
    fpu_op = OP_IDLE;
    fpu_a  = '0;
    fpu_b  = '0;
    if (state == ST_EXEC || state == ST_DIV_WAIT) begin
      fpu_op = op_legal ? op_q : OP_IDLE;
      fpu_a  = a_q;
      fpu_b  = b_q;
    end
  end

  always_comb begin
    state_nx = state;
    cap_ok   = 1'b0;
    cap_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        if (!op_legal) begin
          cap_err  = 1'b1;
          state_nx = ST_RESP;
        end else if (op_div) begin
          state_nx = ST_DIV_WAIT;
        end else begin
          cap_ok   = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_DIV_WAIT: begin
        if (!fpu_busy) begin
          cap_ok   = 1'b1;
          state_nx = ST_RESP;
        end else if (cnt == CNT_LAST) begin
          cap_err  = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt     <= '0;
      out_res <= '0;
      out_tag <= '0;
      out_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= in_op;
        a_q   <= in_a;
        b_q   <= in_b;
        tag_q <= in_tag;
      end
      if (state == ST_EXEC) begin
        cnt <= '0;
      end else if (state == ST_DIV_WAIT &&
                   cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (cap_ok) begin
        out_res <= fpu_res;
        out_err <= 1'b0;
        out_tag <= tag_q;
      end else if (cap_err) begin
        out_res <= '0;
        out_err <= 1'b1;
        out_tag <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: FPU/divider environment model,
// per-cycle transaction scoreboard and directed+random traffic.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int DW = 64;
  localparam int TW = 4;
  localparam int DT = 96;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_res;
  logic [TW-1:0] out_tag;
  logic          out_err;
  logic [3:0]    fpu_op;
  logic [DW-1:0] fpu_a, fpu_b;
  logic          fpu_busy;
  logic [DW-1:0] fpu_res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .DATA_W(DW), .TAG_W(TW), .DIV_TIMEOUT(DT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag),
    .out_err(out_err),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_busy(fpu_busy), .fpu_res(fpu_res)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm,
                      input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  task automatic chki(input string nm,
                      input int act, input int exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  // ---------------- FPU environment semantics ----------------
  function automatic logic legal_op(input logic [3:0] op);
    return op inside {[4'd0:4'd6], [4'd8:4'd10],
                      4'd12, 4'd13};
  endfunction

  function automatic logic [63:0] alu(
      input logic [3:0] op,
      input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_MUL: begin
        p = $signed({{64{a[63]}}, a}) *
            $signed({{64{b[63]}}, b});
        p = p >>> 15;
        return p[63:0];
      end
      OP_CPSGN:  return {b[63], a[62:0]};
      OP_CPSGNN: return {~b[63], a[62:0]};
      OP_XORSGN: return {a[63] ^ b[63], a[62:0]};
      OP_LE: return ($signed(a) <= $signed(b)) ? Q15_ONE : 64'd0;
      OP_LT: return ($signed(a) <  $signed(b)) ? Q15_ONE : 64'd0;
      OP_EQ: return (a == b) ? Q15_ONE : 64'd0;
      OP_MIN: return ($signed(a) < $signed(b)) ? a : b;
      OP_MAX: return ($signed(a) < $signed(b)) ? b : a;
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  function automatic logic [63:0] quot(
      input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] n, d, q;
    n = $signed({{64{a[63]}}, a}) <<< 15;
    d = $signed({{64{b[63]}}, b});
    if (d == 0) return '1;
    q = n / d;
    return q[63:0];
  endfunction

  // Divider: launches on an edge with op=DIV and busy=0
  int          div_lat = 34;
  logic        div_hang = 1'b0;
  logic        busy_q = 1'b0;
  int          dcnt = 0;
  logic [63:0] dq = '0;

  always @(posedge clk) begin
    if (!busy_q && fpu_op == OP_DIV) begin
      dq <= quot(fpu_a, fpu_b);
      if (div_hang) begin
        busy_q <= 1'b1;
        dcnt   <= 3;
      end else if (div_lat == 0) begin
        busy_q <= 1'b0;
      end else begin
        busy_q <= 1'b1;
        dcnt   <= div_lat;
      end
    end else if (busy_q && !div_hang) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) busy_q <= 1'b0;
    end
  end

  assign fpu_busy = busy_q;
  assign fpu_res  = (fpu_op == OP_DIV) ? dq :
                    alu(fpu_op, fpu_a, fpu_b);

  // ---------------- transaction reference model ----------------
  function automatic logic exp_err(input logic [3:0] op,
                                   input int lat,
                                   input logic hang);
    if (!legal_op(op)) return 1'b1;
    if (op == OP_DIV) return hang || lat > DT - 1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_res(
      input logic [3:0] op, input logic [63:0] a,
      input logic [63:0] b, input int lat,
      input logic hang);
    if (exp_err(op, lat, hang)) return '0;
    if (op == OP_DIV) return quot(a, b);
    return alu(op, a, b);
  endfunction

  // Edges from accept until out_valid is seen high
  function automatic int exp_lat(input logic [3:0] op,
                                 input int lat,
                                 input logic hang);
    if (!legal_op(op) || op != OP_DIV) return 1;
    if (hang || lat > DT - 1) return DT + 1;
    return lat + 2;
  endfunction

  int          cyc = 0;
  int          acc_cnt = 0, hs_cnt = 0;
  int          acc_cyc = 0, hs_cyc = 0;
  int          due = 0;
  logic        pend = 1'b0;
  logic [3:0]  e_op = '0;
  logic [63:0] e_a = '0, e_b = '0, e_res = '0;
  logic [3:0]  e_tag = '0;
  logic        e_err = 1'b0;
  logic [63:0] hs_res = '0;
  logic [3:0]  hs_tag = '0;
  logic        hs_err = 1'b0;
  logic        saw_op7 = 1'b0;

  always @(posedge clk) begin : model
    logic m_ready, m_valid;
    m_ready = !pend && !busy_q;
    m_valid = pend && cyc >= due;
    cyc <= cyc + 1;
    if (fpu_op == 4'b0111) saw_op7 <= 1'b1;
    if (!reset) begin
      pend <= 1'b0;
    end else begin
      if (m_valid && out_ready) begin
        pend   <= 1'b0;
        hs_cnt <= hs_cnt + 1;
        hs_cyc <= cyc + 1;
        hs_res <= out_res;
        hs_tag <= out_tag;
        hs_err <= out_err;
      end
      if (in_valid && m_ready) begin
        pend    <= 1'b1;
        acc_cnt <= acc_cnt + 1;
        acc_cyc <= cyc + 1;
        e_op    <= in_op;
        e_a     <= in_a;
        e_b     <= in_b;
        e_tag   <= in_tag;
        e_err   <= exp_err(in_op, div_lat, div_hang);
        e_res   <= exp_res(in_op, in_a, in_b,
                           div_lat, div_hang);
        due     <= cyc + 1 +
                   exp_lat(in_op, div_lat, div_hang);
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic live, xv, wk;
    live = reset && pend;
    xv   = live && cyc >= due;
    wk   = live && cyc < due;
    chkb("in_ready", in_ready, !live && !busy_q);
    chkb("out_valid", out_valid, xv);
    if (xv) begin
      chk("out_res", out_res, e_res);
      chk("out_tag", 64'(out_tag), 64'(e_tag));
      chkb("out_err", out_err, e_err);
    end
    chk("fpu_op", 64'(fpu_op),
        64'((wk && legal_op(e_op)) ? e_op : 4'd0));
    chk("fpu_a", fpu_a, wk ? e_a : 64'd0);
    chk("fpu_b", fpu_b, wk ? e_b : 64'd0);
  end

  // ---------------- stimulus ----------------
  logic rnd_ready = 1'b0;

  task automatic issue(input logic [3:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic [3:0] tag);
    int n0 = acc_cnt;
    int k = 0;
    in_op = op; in_a = a; in_b = b; in_tag = tag;
    in_valid = 1'b1;
    while (acc_cnt == n0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    if (acc_cnt == n0) begin
      checks++; errors++;
      $display("FAIL accept_wait: no accept in %0d cycles", k);
    end
  endtask

  task automatic wait_resp();
    int n0 = hs_cnt;
    int k = 0;
    while (hs_cnt == n0 && k < 300) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      k++;
    end
    if (hs_cnt == n0) begin
      checks++; errors++;
      $display("FAIL resp_wait: no response in %0d cycles", k);
    end
  endtask

  initial begin
    int h0, k;
    logic [31:0] wa, wb;
    logic [3:0] op;

    repeat (3) @(negedge clk);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_res", out_res, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chkb("rst_out_err", out_err, 1'b0);
    chk("rst_fpu_op", 64'(fpu_op), 64'd0);
    chkb("rst_in_ready", in_ready, 1'b1);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    issue(OP_ADD, 64'hC000, 64'h10000, 4'd5);
    wait_resp();
    chk("add_res", hs_res, 64'h1C000);
    chkb("add_err", hs_err, 1'b0);
    chk("add_tag", 64'(hs_tag), 64'd5);
    chki("add_lat", hs_cyc - acc_cyc, 2);

    out_ready = 1'b0;
    issue(OP_ADD, 64'hC000, 64'h10000, 4'd9);
    repeat (5) @(negedge clk);
    chkb("hold_in_ready", in_ready, 1'b0);
    chk("hold_res", out_res, 64'h1C000);
    h0 = hs_cnt;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chki("hold_hs_count", hs_cnt - h0, 1);
    chk("hold_tag", 64'(hs_tag), 64'd9);

    issue(OP_MUL, 64'h10000, 64'h18000, 4'd3);
    wait_resp();
    chk("mul_res", hs_res, 64'h30000);

    div_lat = 34;
    issue(OP_DIV, 64'h30000, 64'h10000, 4'd7);
    wait_resp();
    chk("div_res", hs_res, 64'h18000);
    chkb("div_err", hs_err, 1'b0);
    chki("div_lat", hs_cyc - acc_cyc, 37);
    chkb("div_relaunch_ready", in_ready, 1'b0);

    issue(4'b0111, 64'd5, 64'd7, 4'd2);
    wait_resp();
    chkb("ill_err", hs_err, 1'b1);
    chk("ill_res", hs_res, 64'd0);
    chki("ill_lat", hs_cyc - acc_cyc, 2);

    div_hang = 1'b1;
    issue(OP_DIV, 64'h30000, 64'h10000, 4'd4);
    wait_resp();
    chkb("to_err", hs_err, 1'b1);
    chk("to_res", hs_res, 64'd0);
    chki("to_cycles", (hs_cyc - 1) - (acc_cyc + 1), 96);
    repeat (3) @(negedge clk);
    chkb("to_in_ready", in_ready, 1'b0);
    div_hang = 1'b0;

    div_lat = 34;
    issue(OP_DIV, 64'h30000, 64'h10000, 4'd6);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chkb("arst_out_valid", out_valid, 1'b0);
    chk("arst_fpu_op", 64'(fpu_op), 64'd0);
    chk("arst_fpu_a", fpu_a, 64'd0);
    chkb("arst_in_ready", in_ready, !fpu_busy);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    k = 0;
    while (fpu_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chkb("arst_ready_after", in_ready, 1'b1);
    issue(OP_ADD, 64'h8000, 64'h8000, 4'd1);
    wait_resp();
    chk("arst_add_res", hs_res, 64'h10000);

    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = OP_DIV;
      wa = $urandom;
      wb = $urandom | 32'd1;
      div_lat = ($urandom_range(0, 7) == 0) ? 100 :
                int'($urandom_range(0, 40));
      issue(op, {{32{wa[31]}}, wa}, {{32{wb[31]}}, wb},
            4'($urandom_range(0, 15)));
      wait_resp();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    chkb("never_op7", saw_op7, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name:
fpu_issue_ctrl

Overview:
Initiator-side controller for the fixed-point FPU (Q15, 64-bit signed). It accepts one operation at a time from the core over a valid/ready request channel and drives the FPU operand and opcode lines. It sequences the multi-cycle divide through the FPU's combinational launch/busy interface and returns the result, tag and error flag on a valid/ready response channel. It sits between the execute stage and the FPU, so no other block drives the FPU directly.

Parameters:
DATA_W, 64, operand/result width (Q15 fixed-point, signed)
TAG_W, 4, opaque request tag returned unchanged with the result
DIV_TIMEOUT, 96, maximum cycles spent in DIV_WAIT before the divide is aborted with an error

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready at clk edge
in_op  in  4  FPU opcode
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
in_tag  in  TAG_W  request tag
out_valid  out  1  response valid
out_ready  in  1  response consumed when out_valid & out_ready
out_res  out  DATA_W  result
out_tag  out  TAG_W  tag of the completed request
out_err  out  1  illegal opcode or divide timeout
fpu_op  out  4  opcode to the FPU
fpu_a  out  DATA_W  operand A to the FPU
fpu_b  out  DATA_W  operand B to the FPU
fpu_busy  in  1  FPU busy (divider running)
fpu_res  in  DATA_W  FPU result (combinational)

Behaviour:
- States: IDLE, EXEC, DIV_WAIT, RESP. Encoding is in a 2-bit register.
- Reset (reset=0, async): state=IDLE; out_valid=0; out_res=0; out_tag=0; out_err=0; op/a/b/tag registers=0; timeout counter=0.
- in_ready = (state==IDLE) & !fpu_busy. It stays low while a stale divide runs (see relaunch below).
- IDLE: on accept, register in_op/in_a/in_b/in_tag and go to EXEC.
- FPU drive: in EXEC and DIV_WAIT, fpu_op/fpu_a/fpu_b = the registered values. In IDLE and RESP, fpu_op=4'b0000 and fpu_a=fpu_b=0, so opcode 0011 is never driven outside a divide.
- Legal opcodes: 0000-0010, 0011, 0100-0110, 1000-1010, 1100, 1101. Any other opcode goes EXEC->RESP with out_err=1 and out_res=0. For an illegal opcode, fpu_op is driven as 4'b0000 in EXEC.
- EXEC, non-divide: capture out_res=fpu_res and out_err=0 at the end of the cycle, then go to RESP. out_valid rises 2 cycles after the accept edge.
- EXEC, divide: fpu_busy is 0 (guaranteed by in_ready), so the FPU launches at the EXEC->DIV_WAIT edge. Clear the counter.
- DIV_WAIT: the counter increments each cycle.
  - If fpu_busy==0: capture fpu_res with out_err=0 and go to RESP. A divider that finishes with zero extra latency is handled by this same path.
  - Else if counter==DIV_TIMEOUT-1: set out_err=1, out_res=0, go to RESP.
- Relaunch: the capture cycle has fpu_op=0011 and busy=0, so the FPU relaunches at that edge with the same operands. This is tolerated; the result is discarded. in_ready then stays low until fpu_busy falls. A timeout abort likewise leaves in_ready low until busy clears.
- RESP: out_valid=1. out_res/out_tag/out_err are held stable until out_valid & out_ready, then go to IDLE. No accept in RESP, so the minimum issue interval is 3 cycles.
- Counter: width is clog2(DIV_TIMEOUT)+1; it saturates and never wraps.
- Reset mid-divide: the controller returns to IDLE immediately. in_ready then follows fpu_busy.

Decomposition:
- Shared package fpu_pkg holds:
  - opcode localparams: OP_ADD=4'b0000, OP_SUB, OP_MUL, OP_DIV=4'b0011, OP_CPSGN, OP_CPSGNN, OP_XORSGN, OP_LE, OP_LT, OP_EQ, OP_MIN, OP_MAX;
  - OP_IDLE=4'b0000;
  - the state enum;
  - the Q15 constant Q15_ONE=64'h8000.
- One sub-module is natural: fpu_op_legal, a combinational opcode-legality/is-divide decoder that is also reusable by the instruction decoder.

Test Plan:
- Add, then response channel: A=0xC000 (1.5), B=0x10000 (2.0), op 0000, out_ready=1 -> out_valid at accept+2, out_res=0x1C000, out_err=0, tag echoed. Response hold: the same request with out_ready=0 for 5 cycles -> out_res/out_tag stable, in_ready=0, single handshake on release.
- Mul: A=0x10000 (2.0), B=0x18000 (3.0), op 0010 -> out_res=0x30000.
- Divide with a bench divider model (busy 34 cycles): A=0x30000 (6.0), B=0x10000 (2.0) -> out_res=0x18000, out_err=0. in_ready stays 0 until the relaunched divide's busy clears.
- Illegal opcode: op 0111, A=5, B=7 -> out_err=1, out_res=0, fpu_op never 0111, out_valid at accept+2.
- Timeout: divider model holds busy=1 forever, DIV_TIMEOUT=96 -> out_err=1, out_res=0 exactly 96 cycles after entering DIV_WAIT, and in_ready=0 afterwards.
- Async reset: assert reset=0 mid-DIV_WAIT between clock edges -> out_valid=0 and state=IDLE immediately. After release with fpu_busy=0, in_ready=1 and a following add completes correctly.
